// File: rtl/reg_file_wp_pkg.sv
// rtl/reg_file_wp_pkg.sv - shared widths and debug handshake state encoding
package reg_file_wp_pkg;

   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_REG_ADDR_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      ACK  = 2'd2
   } dbg_state_t;

endpackage

// File: rtl/reg_file_wp_if.sv
// rtl/reg_file_wp_if.sv - write-back, ID read and host debug signals of the register file
interface reg_file_wp_if
   import reg_file_wp_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
);
   logic                      reg_wen_in;
   logic [REG_ADDR_WIDTH-1:0] rd_addr_in;
   logic [DATA_WIDTH-1:0]     wdata_in;
   logic [REG_ADDR_WIDTH-1:0] rs1_addr;
   logic [DATA_WIDTH-1:0]     rs1_data;
   logic [REG_ADDR_WIDTH-1:0] rs2_addr;
   logic [DATA_WIDTH-1:0]     rs2_data;
   logic                      dbg_req;
   logic                      dbg_we;
   logic [REG_ADDR_WIDTH-1:0] dbg_addr;
   logic [DATA_WIDTH-1:0]     dbg_wdata;
   logic                      dbg_ack;
   logic [DATA_WIDTH-1:0]     dbg_rdata;

   modport master (
      output reg_wen_in, rd_addr_in, wdata_in, rs1_addr, rs2_addr,
             dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  rs1_data, rs2_data, dbg_ack, dbg_rdata
   );

   modport slave (
      input  reg_wen_in, rd_addr_in, wdata_in, rs1_addr, rs2_addr,
             dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output rs1_data, rs2_data, dbg_ack, dbg_rdata
   );
endinterface

// File: rtl/reg_file_dbg_fsm.sv
// rtl/reg_file_dbg_fsm.sv - four-phase host handshake with holding regs and WB contention stall
module reg_file_dbg_fsm
   import reg_file_wp_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      dbg_req,
   input  logic                      dbg_we,
   input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0]     dbg_wdata,
   input  logic                      reg_wen,
   input  logic [DATA_WIDTH-1:0]     host_rvalue,
   output logic                      dbg_ack,
   output logic [DATA_WIDTH-1:0]     dbg_rdata,
   output logic                      host_wen,
   output logic [REG_ADDR_WIDTH-1:0] host_waddr,
   output logic [DATA_WIDTH-1:0]     host_wdata,
   output logic [REG_ADDR_WIDTH-1:0] host_raddr
);
   dbg_state_t                state;
   logic                      hold_we;
   logic [REG_ADDR_WIDTH-1:0] hold_addr;
   logic [DATA_WIDTH-1:0]     hold_wdata;

   // WB owns the write port; a pending host write simply waits for a free cycle
   assign host_wen   = (state == PEND) && hold_we && !reg_wen;
   assign host_waddr = hold_addr;
   assign host_wdata = hold_wdata;
   assign host_raddr = hold_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dbg_ack    <= 1'b0;
         dbg_rdata  <= '0;
         hold_we    <= 1'b0;
         hold_addr  <= '0;
         hold_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               dbg_ack <= 1'b0;
               if (dbg_req) begin
                  hold_we    <= dbg_we;
                  hold_addr  <= dbg_addr;
                  hold_wdata <= dbg_wdata;
                  state      <= PEND;
               end
            end
            PEND: begin
               if (!hold_we) begin
                  dbg_rdata <= host_rvalue;
                  dbg_ack   <= 1'b1;
                  state     <= ACK;
               end else if (!reg_wen) begin
                  dbg_ack <= 1'b1;
                  state   <= ACK;
               end
            end
            ACK: begin
               if (!dbg_req) begin
                  dbg_ack <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               dbg_ack <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: rtl/reg_file_wp.sv
// rtl/reg_file_wp.sv - register file with WB write port, bypassed read ports and host debug port
module reg_file_wp
   import reg_file_wp_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   reg_file_wp_if.slave  bus
);
   localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

   logic [DATA_WIDTH-1:0]     regs [NUM_REGS];
   logic                      host_wen;
   logic [REG_ADDR_WIDTH-1:0] host_waddr;
   logic [DATA_WIDTH-1:0]     host_wdata;
   logic [REG_ADDR_WIDTH-1:0] host_raddr;
   logic [DATA_WIDTH-1:0]     host_rvalue;

   // Write-first: an in-flight WB result wins over the stored copy
   function automatic logic [DATA_WIDTH-1:0] fwd(
      input logic                      wen,
      input logic [REG_ADDR_WIDTH-1:0] waddr,
      input logic [DATA_WIDTH-1:0]     wdata,
      input logic [REG_ADDR_WIDTH-1:0] raddr,
      input logic [DATA_WIDTH-1:0]     stored
   );
      return (wen && (waddr == raddr)) ? wdata : stored;
   endfunction

   assign bus.rs1_data = fwd(bus.reg_wen_in, bus.rd_addr_in, bus.wdata_in,
                             bus.rs1_addr, regs[bus.rs1_addr]);
   assign bus.rs2_data = fwd(bus.reg_wen_in, bus.rd_addr_in, bus.wdata_in,
                             bus.rs2_addr, regs[bus.rs2_addr]);
   assign host_rvalue  = fwd(bus.reg_wen_in, bus.rd_addr_in, bus.wdata_in,
                             host_raddr, regs[host_raddr]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (bus.reg_wen_in) begin
         regs[bus.rd_addr_in] <= bus.wdata_in;
      end else if (host_wen) begin
         regs[host_waddr] <= host_wdata;
      end
   end

   reg_file_dbg_fsm #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_dbg_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .dbg_req     (bus.dbg_req),
      .dbg_we      (bus.dbg_we),
      .dbg_addr    (bus.dbg_addr),
      .dbg_wdata   (bus.dbg_wdata),
      .reg_wen     (bus.reg_wen_in),
      .host_rvalue (host_rvalue),
      .dbg_ack     (bus.dbg_ack),
      .dbg_rdata   (bus.dbg_rdata),
      .host_wen    (host_wen),
      .host_waddr  (host_waddr),
      .host_wdata  (host_wdata),
      .host_raddr  (host_raddr)
   );
endmodule

// File: tb/tb_reg_file_wp.sv
// tb/tb_reg_file_wp.sv - randomized self-checking bench for reg_file_wp against an array model
module tb_reg_file_wp;
   import reg_file_wp_pkg::*;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int N  = 2 ** AW;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   reg_file_wp_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

   reg_file_wp #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int            n_chk  = 0;
   int            n_fail = 0;
   logic [DW-1:0] mdl [N];

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) mdl[i] = '0;
   endtask

   task automatic sweep_regs();
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         bus.reg_wen_in = 1'b0;
         bus.rs1_addr   = AW'(i);
         bus.rs2_addr   = AW'(N - 1 - i);
         #1;
         chk("sweep_rs1", bus.rs1_data, mdl[i]);
         chk("sweep_rs2", bus.rs2_data, mdl[N-1-i]);
      end
   endtask

   // nwb cycles of WB traffic to wa are driven while the host request is pending
   task automatic host_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input int nwb, input logic [AW-1:0] wa, input logic [DW-1:0] wv);
      logic [DW-1:0] exp_rd;
      int            lat;
      @(negedge clk);
      bus.reg_wen_in = 1'b0;
      bus.dbg_req    = 1'b1;
      bus.dbg_we     = we;
      bus.dbg_addr   = addr;
      bus.dbg_wdata  = wd;
      exp_rd = (nwb > 0 && wa == addr) ? wv : mdl[addr];
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         lat = c;
         if (bus.dbg_ack) break;
         if (c == 1) begin
            bus.dbg_we    = ~we;
            bus.dbg_addr  = AW'($urandom_range(0, N - 1));
            bus.dbg_wdata = $urandom;
         end
         if (c <= nwb) begin
            bus.reg_wen_in = 1'b1;
            bus.rd_addr_in = wa;
            bus.wdata_in   = wv;
            mdl[wa]        = wv;
         end else begin
            bus.reg_wen_in = 1'b0;
         end
         if (c == 20) lat = 21;
      end
      bus.reg_wen_in = 1'b0;
      chk("ack_latency", DW'(lat), DW'(2 + (we ? nwb : 0)));
      if (we) mdl[addr] = wd;
      else    chk("dbg_rdata", bus.dbg_rdata, exp_rd);
      repeat (2) @(negedge clk);
      chk("ack_hold", DW'(bus.dbg_ack), 32'd1);
      bus.dbg_req = 1'b0;
      @(negedge clk);
      chk("ack_drop", DW'(bus.dbg_ack), 32'd0);
   endtask

   initial begin
      logic [DW-1:0] e1, e2;
      rst_n          = 1'b0;
      bus.reg_wen_in = 1'b0;
      bus.rd_addr_in = '0;
      bus.wdata_in   = '0;
      bus.rs1_addr   = 4'd3;
      bus.rs2_addr   = 4'd15;
      bus.dbg_req    = 1'b0;
      bus.dbg_we     = 1'b0;
      bus.dbg_addr   = '0;
      bus.dbg_wdata  = '0;
      clear_model();
      #12;
      chk("rst_rs1", bus.rs1_data, 32'h0);
      chk("rst_rs2", bus.rs2_data, 32'h0);
      chk("rst_ack", DW'(bus.dbg_ack), 32'd0);
      chk("rst_rdata", bus.dbg_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      @(negedge clk);
      bus.reg_wen_in = 1'b1;
      bus.rd_addr_in = 4'd5;
      bus.wdata_in   = 32'hDEADBEEF;
      bus.rs1_addr   = 4'd5;
      #1;
      chk("wb_bypass", bus.rs1_data, 32'hDEADBEEF);
      mdl[5] = 32'hDEADBEEF;
      @(negedge clk);
      bus.reg_wen_in = 1'b0;
      #1;
      chk("wb_stored", bus.rs1_data, 32'hDEADBEEF);

      host_txn(1'b1, 4'd7, 32'h12345678, 0, 4'd0, 32'h0);
      sweep_regs();
      host_txn(1'b1, 4'd2, 32'hAAAA0000, 3, 4'd9, 32'h55);
      sweep_regs();
      host_txn(1'b0, 4'd4, 32'h0, 1, 4'd4, 32'hCAFEF00D);

      @(negedge clk);
      bus.dbg_req   = 1'b1;
      bus.dbg_we    = 1'b1;
      bus.dbg_addr  = 4'd11;
      bus.dbg_wdata = 32'h11111111;
      bus.rs1_addr  = 4'd11;
      bus.rs2_addr  = 4'd5;
      @(negedge clk);
      #1;
      rst_n       = 1'b0;
      bus.dbg_req = 1'b0;
      clear_model();
      #1;
      chk("rstpend_ack", DW'(bus.dbg_ack), 32'd0);
      chk("rstpend_r11", bus.rs1_data, 32'h0);
      chk("rstpend_r5", bus.rs2_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      host_txn(1'b1, 4'd11, 32'hBEEF0001, 0, 4'd0, 32'h0);
      sweep_regs();

      repeat (15) begin
         logic we;
         we = 1'($urandom_range(0, 1));
         host_txn(we, AW'($urandom_range(0, N - 1)), $urandom,
                  we ? $urandom_range(0, 3) : $urandom_range(0, 1),
                  AW'($urandom_range(0, N - 1)), $urandom);
      end
      sweep_regs();

      repeat (200) begin
         @(negedge clk);
         bus.reg_wen_in = 1'($urandom_range(0, 1));
         bus.rd_addr_in = AW'($urandom_range(0, N - 1));
         bus.wdata_in   = $urandom;
         bus.rs1_addr   = AW'($urandom_range(0, N - 1));
         bus.rs2_addr   = AW'($urandom_range(0, N - 1));
         #1;
         e1 = (bus.reg_wen_in && bus.rd_addr_in == bus.rs1_addr) ? bus.wdata_in : mdl[bus.rs1_addr];
         e2 = (bus.reg_wen_in && bus.rd_addr_in == bus.rs2_addr) ? bus.wdata_in : mdl[bus.rs2_addr];
         chk("rand_rs1", bus.rs1_data, e1);
         chk("rand_rs2", bus.rs2_data, e2);
         if (bus.reg_wen_in) mdl[bus.rd_addr_in] = bus.wdata_in;
      end
      sweep_regs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_file_wp.md
# reg_file_wp

Architectural register file terminating the write-back path: accepts the write port driven by the WB stage, serves the two combinational read ports used by the ID stage with same-cycle write-through bypass, and exposes a four-phase debug/host access port for inspecting and loading registers from outside the pipeline. It sits inside the ID stage and is the storage endpoint for every retired result.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- REG_ADDR_WIDTH, 4, register address width; NUM_REGS = 2**REG_ADDR_WIDTH

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- reg_wen_in  in  1  WB write enable
- rd_addr_in  in  REG_ADDR_WIDTH  WB destination register
- wdata_in  in  DATA_WIDTH  WB write data
- rs1_addr  in  REG_ADDR_WIDTH  ID read port 1 address
- rs1_data  out  DATA_WIDTH  ID read port 1 data (combinational)
- rs2_addr  in  REG_ADDR_WIDTH  ID read port 2 address
- rs2_data  out  DATA_WIDTH  ID read port 2 data (combinational)
- dbg_req  in  1  host request, held high until dbg_ack seen
- dbg_we  in  1  1 = write, 0 = read; valid while dbg_req high
- dbg_addr  in  REG_ADDR_WIDTH  host register address
- dbg_wdata  in  DATA_WIDTH  host write data
- dbg_ack  out  1  registered acknowledge
- dbg_rdata  out  DATA_WIDTH  registered host read data, valid when dbg_ack high

## Operation
- Storage: NUM_REGS x DATA_WIDTH flops; all registers writable (no hardwired zero).
- WB write: reg_wen_in=1 writes wdata_in to regs[rd_addr_in] at the rising edge.
- Read ports: rsN_data = (reg_wen_in && rd_addr_in==rsN_addr) ? wdata_in : regs[rsN_addr]. Bypass is write-first; no other forwarding here.
- Debug FSM states IDLE, PEND, ACK:
  - IDLE: dbg_ack=0. dbg_req=1 -> capture dbg_we/dbg_addr/dbg_wdata into holding regs, go PEND.
  - PEND: read -> sample bypassed value of captured addr into dbg_rdata, go ACK. Write with reg_wen_in=0 -> write regs[addr], go ACK. Write with reg_wen_in=1 -> WB has priority, stay PEND (no host write that cycle).
  - ACK: dbg_ack=1. dbg_req=0 -> IDLE. dbg_req=1 -> stay ACK.
- Host inputs changing after capture are ignored until next IDLE.
- WB and host never write the same cycle; WB is never stalled.

## Timing
- Reset (rst_n low, any time, including mid-handshake): all regs=0, FSM=IDLE, dbg_ack=0, dbg_rdata=0, holding regs=0. Read ports reflect zeros immediately (combinational).
- WB write latency: visible on read ports same cycle via bypass; in storage after the edge.
- Debug latency: req high sampled at edge N -> PEND; edge N+1 performs access -> dbg_ack high from N+1; minimum 2 cycles req-to-ack. Each cycle of WB write contention adds 1 cycle.
- Debug write to register X is visible on read ports from the cycle after the PEND edge.
- Debug read in PEND while WB writes the same address returns the WB data (bypass).
- dbg_ack held high while dbg_req high; falls one edge after dbg_req drops. New request accepted only from IDLE.

## Structure
- Shared package: state encoding (IDLE=2'd0, PEND=2'd1, ACK=2'd2), default DATA_WIDTH/REG_ADDR_WIDTH constants.
- One sub-module: reg_file_dbg_fsm (handshake FSM, holding regs, dbg_ack/dbg_rdata, contention stall); emits write strobe/addr/data and read addr to the top, which owns storage and bypass muxes.

## Test plan
- Reset then read rs1=3, rs2=15 -> both 0x00000000; dbg_ack=0.
- WB write r5=0xDEADBEEF with rs1_addr=5 same cycle -> rs1_data=0xDEADBEEF that cycle and next cycle (after reg_wen_in drops).
- Host write r7=0x12345678 (req held) -> dbg_ack rises 2 edges after req; rs2_addr=7 reads 0x12345678; drop req -> ack low one edge later.
- Host write r2=0xAAAA0000 while reg_wen_in=1 for 3 cycles writing r9=0x55 -> ack delayed 3 cycles; afterwards r2=0xAAAA0000, r9=0x55.
- Host read r4 in PEND while WB writes r4=0xCAFEF00D -> dbg_rdata=0xCAFEF00D.
- rst_n asserted while FSM in PEND for a write -> target register remains 0, dbg_ack=0, FSM IDLE; new request completes normally.
